// File: rtl/qupls_mem_issue_arb.sv
// Memory-op issue arbiter: a small in-order FIFO of dual-issued memory ops drained one at a time onto the data-cache port.
// Optional performance counters are enabled with `define QUPLS_MEM_ARB_PERF_EN.
module qupls_mem_issue_arb #(
    parameter int QDEPTH      = 4,
    parameter int ROB_ENTRIES = 16,
    parameter int NDX_W       = 4,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i0_v,
    input  logic [NDX_W-1:0]       i0_ndx,
    input  logic                   i0_store,
    input  logic [ADDR_W-1:0]      i0_adr,
    input  logic                   i1_v,
    input  logic [NDX_W-1:0]       i1_ndx,
    input  logic                   i1_store,
    input  logic [ADDR_W-1:0]      i1_adr,
    input  logic [ROB_ENTRIES-1:0] stomp,
    output logic                   q_full,
    output logic                   dc_req,
    output logic                   dc_we,
    output logic [ADDR_W-1:0]      dc_adr,
    output logic [NDX_W-1:0]       dc_tag,
    input  logic                   dc_ack,
    input  logic                   dc_err,
    output logic                   done_v,
    output logic [NDX_W-1:0]       done_ndx,
    output logic                   done_err,
    output logic                   busy
`ifdef QUPLS_MEM_ARB_PERF_EN
    ,
    output logic [31:0]            perf_ops,
    output logic [15:0]            perf_timeouts,
    output logic [15:0]            perf_skips
`endif
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    logic [NDX_W-1:0]  ndx_mem   [QDEPTH];
    logic              store_mem [QDEPTH];
    logic [ADDR_W-1:0] adr_mem   [QDEPTH];
    logic [QDEPTH-1:0] valid_reg, valid_next;
    logic [PW-1:0]     head_reg, tail_reg, wr1_ptr;
    logic [CW-1:0]     count_reg;
    state_t            state_reg, state_next;
    logic [TW-1:0]     tmo_reg;
    logic              kill_reg, err_reg;
    logic              dc_we_reg, done_v_reg, done_err_reg;
    logic [ADDR_W-1:0] dc_adr_reg;
    logic [NDX_W-1:0]  dc_tag_reg, done_ndx_reg;
    logic              enq0, enq1, pop, load, head_ok, timed_out;

    assign q_full    = count_reg > CW'(QDEPTH - 2);
    assign enq0      = i0_v & ~q_full;
    assign enq1      = i1_v & ~q_full;
    assign wr1_ptr   = tail_reg + PW'(enq0);
    assign head_ok   = valid_reg[head_reg] & ~stomp[ndx_mem[head_reg]];
    assign timed_out = (tmo_reg == TW'(TIMEOUT - 1));

    assign dc_req   = (state_reg == REQ);
    assign dc_we    = dc_we_reg;
    assign dc_adr   = dc_adr_reg;
    assign dc_tag   = dc_tag_reg;
    assign done_v   = done_v_reg;
    assign done_ndx = done_ndx_reg;
    assign done_err = done_err_reg;
    assign busy     = (count_reg != '0) || (state_reg != IDLE);

    // Fresh writes take their stomp bit directly; resident entries are cleared by stomp or pop.
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_valid
        assign valid_next[gi] = (enq0 && tail_reg == PW'(gi)) ? ~stomp[i0_ndx] :
                                (enq1 && wr1_ptr == PW'(gi))  ? ~stomp[i1_ndx] :
                                valid_reg[gi] & ~stomp[ndx_mem[gi]] &
                                ~(pop && head_reg == PW'(gi));
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    if (head_ok) begin
                        load       = 1'b1;
                        state_next = REQ;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dc_ack || timed_out) begin
                    pop        = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq0) begin
            ndx_mem[tail_reg]   <= i0_ndx;
            store_mem[tail_reg] <= i0_store;
            adr_mem[tail_reg]   <= i0_adr;
        end
        if (enq1) begin
            ndx_mem[wr1_ptr]   <= i1_ndx;
            store_mem[wr1_ptr] <= i1_store;
            adr_mem[wr1_ptr]   <= i1_adr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            valid_reg    <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            tmo_reg      <= '0;
            kill_reg     <= 1'b0;
            err_reg      <= 1'b0;
            dc_we_reg    <= 1'b0;
            dc_adr_reg   <= '0;
            dc_tag_reg   <= '0;
            done_v_reg   <= 1'b0;
            done_ndx_reg <= '0;
            done_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            valid_reg  <= valid_next;
            head_reg   <= head_reg + PW'(pop);
            tail_reg   <= tail_reg + PW'(enq0) + PW'(enq1);
            count_reg  <= count_reg + CW'(enq0) + CW'(enq1) - CW'(pop);
            done_v_reg <= 1'b0;
            if (load) begin
                dc_we_reg  <= store_mem[head_reg];
                dc_adr_reg <= adr_mem[head_reg];
                dc_tag_reg <= ndx_mem[head_reg];
                tmo_reg    <= '0;
                kill_reg   <= 1'b0;
            end else if (state_reg == REQ) begin
                tmo_reg <= tmo_reg + 1'b1;
                if (stomp[dc_tag_reg]) kill_reg <= 1'b1;
                if (dc_ack)         err_reg <= dc_err;
                else if (timed_out) err_reg <= 1'b1;
            end else if (state_reg == DONE) begin
                tmo_reg <= '0;
                // A stomp landing in either REQ or DONE cancels the report, not the bus op.
                if (!kill_reg && !stomp[dc_tag_reg]) begin
                    done_v_reg   <= 1'b1;
                    done_ndx_reg <= dc_tag_reg;
                    done_err_reg <= err_reg;
                end
            end
        end
    end

`ifdef QUPLS_MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_ops      <= '0;
            perf_timeouts <= '0;
            perf_skips    <= '0;
        end else begin
            if (state_reg == DONE && perf_ops != '1)
                perf_ops <= perf_ops + 1'b1;
            if (state_reg == REQ && !dc_ack && timed_out && perf_timeouts != '1)
                perf_timeouts <= perf_timeouts + 1'b1;
            if (state_reg == IDLE && pop && perf_skips != '1)
                perf_skips <= perf_skips + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_qupls_mem_issue_arb.sv
// Directed bench for qupls_mem_issue_arb: a per-cycle vector table plus timeout and reset-mid-request sequences.
module tb_qupls_mem_issue_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        i0_v, i0_store, i1_v, i1_store;
    logic [3:0]  i0_ndx, i1_ndx;
    logic [31:0] i0_adr, i1_adr;
    logic [15:0] stomp;
    logic        q_full, dc_req, dc_we, dc_ack, dc_err, done_v, done_err, busy;
    logic [31:0] dc_adr;
    logic [3:0]  dc_tag, done_ndx;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    qupls_mem_issue_arb #(
        .QDEPTH(4), .ROB_ENTRIES(16), .NDX_W(4), .ADDR_W(32), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i0_v(i0_v), .i0_ndx(i0_ndx), .i0_store(i0_store), .i0_adr(i0_adr),
        .i1_v(i1_v), .i1_ndx(i1_ndx), .i1_store(i1_store), .i1_adr(i1_adr),
        .stomp(stomp), .q_full(q_full),
        .dc_req(dc_req), .dc_we(dc_we), .dc_adr(dc_adr), .dc_tag(dc_tag),
        .dc_ack(dc_ack), .dc_err(dc_err),
        .done_v(done_v), .done_ndx(done_ndx), .done_err(done_err), .busy(busy)
    );

    typedef struct {
        logic        rst_n;
        logic        a0v, a0st, a1v, a1st, ak, er;
        logic [3:0]  a0n, a1n;
        logic [31:0] a0a, a1a;
        logic [15:0] stm;
        logic [13:0] exp_bits;  // {req, we, tag, dv, dndx, derr, qf, busy}
        logic [31:0] exp_adr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rn, input bit a0v, input bit a0st, input int a0n, input int a0a,
                       input bit a1v, input bit a1st, input int a1n, input int a1a,
                       input int stm, input bit ak, input bit er,
                       input bit req, input bit we, input int tag, input int adr,
                       input bit dv, input int dn, input bit de, input bit qf, input bit bz);
        vec_t v;
        v.rst_n = rn; v.a0v = a0v; v.a0st = a0st; v.a0n = 4'(a0n); v.a0a = 32'(a0a);
        v.a1v = a1v; v.a1st = a1st; v.a1n = 4'(a1n); v.a1a = 32'(a1a);
        v.stm = 16'(stm); v.ak = ak; v.er = er;
        v.exp_bits = {req, we, 4'(tag), dv, 4'(dn), de, qf, bz};
        v.exp_adr  = 32'(adr);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        i0_v = 0; i0_store = 0; i0_ndx = 0; i0_adr = 0;
        i1_v = 0; i1_store = 0; i1_ndx = 0; i1_adr = 0;
        stomp = 0; dc_ack = 0; dc_err = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  hi_cnt;
        bit  dropped;
        bit  any_done;

        rst = 1'b0;
        idle_inputs();

        //   rn a0v st n a0a     a1v st n a1a     stm ak er | req we tag adr     dv dn de qf bz
        add(0, 0,0,0,0,          0,0,0,0,         0,   0,0,   0,0,0,0,          0,0,0, 0,0); // reset
        add(1, 1,0,3,'h1000,     0,0,0,0,         0,   0,0,   0,0,0,0,          0,0,0, 0,1); // single load
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   1,0,3,'h1000,     0,0,0, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   1,0,3,'h1000,     0,0,0, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   1,0,   0,0,3,'h1000,     0,0,0, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   0,0,3,'h1000,     1,3,0, 0,0);
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   0,0,3,'h1000,     0,3,0, 0,0);
        add(1, 1,1,5,'h2000,     1,0,6,'h3000,    0,   0,0,   0,0,3,'h1000,     0,3,0, 0,1); // dual issue
        add(1, 1,0,8,'h4000,     0,0,0,0,         0,   0,0,   1,1,5,'h2000,     0,3,0, 1,1); // count 3 -> full
        add(1, 0,0,0,0,          0,0,0,0,         0,   1,0,   0,1,5,'h2000,     0,3,0, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   0,1,5,'h2000,     1,5,0, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   1,0,6,'h3000,     0,5,0, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   1,1,   0,0,6,'h3000,     0,5,0, 0,1); // ack with error
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   0,0,6,'h3000,     1,6,1, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   1,0,8,'h4000,     0,6,1, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   1,0,   0,0,8,'h4000,     0,6,1, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   0,0,8,'h4000,     1,8,0, 0,0);
        add(1, 1,0,1,'h100,      1,0,2,'h200,     0,   0,0,   0,0,8,'h4000,     0,8,0, 0,1); // stomp in queue
        add(1, 1,1,3,'h300,      0,0,0,0,         0,   0,0,   1,0,1,'h100,      0,8,0, 1,1);
        add(1, 0,0,0,0,          0,0,0,0,         'h4, 0,0,   1,0,1,'h100,      0,8,0, 1,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   1,0,   0,0,1,'h100,      0,8,0, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   0,0,1,'h100,      1,1,0, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   0,0,1,'h100,      0,1,0, 0,1); // skip ndx 2
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   1,1,3,'h300,      0,1,0, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   1,0,   0,1,3,'h300,      0,1,0, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   0,1,3,'h300,      1,3,0, 0,0);
        add(1, 1,1,7,'h700,      0,0,0,0,         0,   0,0,   0,1,3,'h300,      0,3,0, 0,1); // stomp in flight
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   1,1,7,'h700,      0,3,0, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         'h80,0,0,   1,1,7,'h700,      0,3,0, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   1,0,   0,1,7,'h700,      0,3,0, 0,1);
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   0,1,7,'h700,      0,3,0, 0,0);
        add(1, 0,0,0,0,          0,0,0,0,         0,   1,1,   0,1,7,'h700,      0,3,0, 0,0); // stray ack
        add(1, 0,0,0,0,          0,0,0,0,         0,   0,0,   0,1,7,'h700,      0,3,0, 0,0);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            rst = vecs[k].rst_n;
            i0_v = vecs[k].a0v; i0_store = vecs[k].a0st; i0_ndx = vecs[k].a0n; i0_adr = vecs[k].a0a;
            i1_v = vecs[k].a1v; i1_store = vecs[k].a1st; i1_ndx = vecs[k].a1n; i1_adr = vecs[k].a1a;
            stomp = vecs[k].stm; dc_ack = vecs[k].ak; dc_err = vecs[k].er;
            tick();
            chk($sformatf("vec%0d_ctl", k),
                64'({dc_req, dc_we, dc_tag, done_v, done_ndx, done_err, q_full, busy}),
                64'(vecs[k].exp_bits));
            chk($sformatf("vec%0d_adr", k), 64'(dc_adr), 64'(vecs[k].exp_adr));
            $display("[TB] vec %0d: req=%0d tag=%0d done_v=%0d done_ndx=%0d busy=%0d",
                     k, dc_req, dc_tag, done_v, done_ndx, busy);
        end

        // Timeout: ndx 9 is never acked, ndx 10 follows normally.
        @(negedge clk);
        idle_inputs();
        i0_v = 1; i0_ndx = 9;  i0_adr = 32'h900;
        i1_v = 1; i1_ndx = 10; i1_adr = 32'hA00; i1_store = 1;
        @(negedge clk);
        idle_inputs();
        hi_cnt  = 0;
        dropped = 0;
        for (int c = 0; c < 40 && !dropped; c++) begin
            tick();
            if (dc_req) hi_cnt++;
            else if (hi_cnt > 0) dropped = 1;
        end
        chk("timeout_dropped", 64'(dropped), 64'd1);
        chk("timeout_req_cycles", 64'(hi_cnt), 64'd8);
        tick();
        chk("timeout_done", 64'({done_v, done_ndx, done_err}), 64'({1'b1, 4'd9, 1'b1}));
        $display("[TB] timeout: req cycles=%0d done_ndx=%0d done_err=%0d", hi_cnt, done_ndx, done_err);
        tick();
        chk("after_timeout_req", 64'({dc_req, dc_we, dc_tag}), 64'({1'b1, 1'b1, 4'd10}));
        chk("after_timeout_adr", 64'(dc_adr), 64'h0A00);
        @(negedge clk);
        dc_ack = 1;
        @(negedge clk);
        dc_ack = 0;
        tick();
        chk("after_timeout_done", 64'({done_v, done_ndx, done_err}), 64'({1'b1, 4'd10, 1'b0}));
        $display("[TB] next op: done_ndx=%0d done_err=%0d", done_ndx, done_err);

        // Reset while a request is outstanding.
        @(negedge clk);
        i0_v = 1; i0_ndx = 12; i0_adr = 32'hC00;
        @(negedge clk);
        idle_inputs();
        tick();
        chk("pre_reset_req", 64'({dc_req, dc_tag}), 64'({1'b1, 4'd12}));
        @(negedge clk);
        rst = 0;
        tick();
        chk("reset_mid_req", 64'({dc_req, busy, q_full, done_v}), 64'd0);
        @(negedge clk);
        rst = 1;
        any_done = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done_v || dc_req) any_done = 1;
        end
        chk("reset_no_done", 64'(any_done), 64'd0);
        $display("[TB] reset mid-REQ: busy=%0d q_full=%0d", busy, q_full);
        @(negedge clk);
        i0_v = 1; i0_ndx = 13; i0_adr = 32'hD00;
        @(negedge clk);
        idle_inputs();
        tick();
        chk("post_reset_req", 64'({dc_req, dc_we, dc_tag}), 64'({1'b1, 1'b0, 4'd13}));
        chk("post_reset_adr", 64'(dc_adr), 64'h0D00);
        @(negedge clk);
        dc_ack = 1;
        @(negedge clk);
        dc_ack = 0;
        tick();
        chk("post_reset_done", 64'({done_v, done_ndx, done_err}), 64'({1'b1, 4'd13, 1'b0}));
        $display("[TB] post-reset op: done_ndx=%0d", done_ndx);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
